// File: rtl/pu_or1k_pfpu32_f2i_rnd_pkg.sv
// Shared pfpu32 definitions for the float-to-integer rounding stage:
// rounding-mode encodings, int32 saturation limits and the align-stage register bundle.
package pu_or1k_pfpu32_f2i_rnd_pkg;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_TOZERO  = 2'b01;
    localparam logic [1:0] RM_UP      = 2'b10;
    localparam logic [1:0] RM_DOWN    = 2'b11;

    localparam logic [31:0] INT32_MAX_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MAX_NEG = 32'h8000_0000;

    typedef struct packed {
        logic        sign;
        logic [31:0] mag;
        logic        g;
        logic        r;
        logic        s;
        logic        ovf;
        logic        snan;
        logic [1:0]  rmode;
    } f2i_s1_t;

endpackage

// File: rtl/pu_or1k_pfpu32_grs_shr.sv
// Combinational 24-bit right shifter producing the shifted magnitude plus
// guard, round and sticky bits; shared by the f2i, i2f and rounding paths.
module pu_or1k_pfpu32_grs_shr (
    input  logic [23:0] int24_i,
    input  logic [4:0]  shr_i,
    output logic [23:0] mag_o,
    output logic        g_o,
    output logic        r_o,
    output logic        s_o
);

    logic [55:0] ext_s;

    // 32 zero bits below the operand keep every shifted-out bit visible for g/r/s
    always_comb begin
        ext_s = {int24_i, 32'h0000_0000} >> shr_i;
        mag_o = ext_s[55:32];
        g_o   = ext_s[31];
        r_o   = ext_s[30];
        s_o   = |ext_s[29:0];
    end

endmodule

// File: rtl/pu_or1k_pfpu32_f2i_rnd.sv
// pfpu32 float-to-integer back end: align, then round/negate/saturate (2 stages).
// Build option OR_PFPU32_F2I_RNDMODES_EN enables all rounding modes; otherwise truncate.
module pu_or1k_pfpu32_f2i_rnd
    import pu_or1k_pfpu32_f2i_rnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        adv_i,
    input  logic [1:0]  rmode_i,
    input  logic        f2i_rdy_i,
    input  logic        f2i_sign_i,
    input  logic [23:0] f2i_int24_i,
    input  logic [4:0]  f2i_shr_i,
    input  logic [3:0]  f2i_shl_i,
    input  logic        f2i_ovf_i,
    input  logic        f2i_snan_i,
    output logic        f2i_rdy_o,
    output logic [31:0] f2i_int32_o,
    output logic        f2i_inexact_o,
    output logic        f2i_invalid_o,
    output logic        f2i_snan_o
);

    f2i_s1_t     s1_q, s1_d, s1_nxt_s;
    logic        rdy1_q, rdy1_d;
    logic        rdy2_q, rdy2_d;
    logic [31:0] int32_q, int32_d;
    logic        inexact_q, inexact_d;
    logic        invalid_q, invalid_d;
    logic        snan_q, snan_d;

    logic [23:0] shr_mag_s;
    logic        shr_g_s, shr_r_s, shr_s_s;

    logic        inc_s;
    logic [32:0] rmag_s;
    logic        rovf_s;
    logic [31:0] int32_s;
    logic        inexact_s;
    logic        invalid_s;

    pu_or1k_pfpu32_grs_shr u_grs_shr (
        .int24_i (f2i_int24_i),
        .shr_i   (f2i_shr_i),
        .mag_o   (shr_mag_s),
        .g_o     (shr_g_s),
        .r_o     (shr_r_s),
        .s_o     (shr_s_s)
    );

    // Stage-1 align: left shift is exact, right shift yields guard/round/sticky
    always_comb begin
        s1_nxt_s       = '0;
        s1_nxt_s.sign  = f2i_sign_i;
        s1_nxt_s.ovf   = f2i_ovf_i;
        s1_nxt_s.snan  = f2i_snan_i;
        s1_nxt_s.rmode = rmode_i;
        if (f2i_shl_i != 4'd0) begin
            s1_nxt_s.mag = {8'h00, f2i_int24_i} << f2i_shl_i;
            s1_nxt_s.g   = 1'b0;
            s1_nxt_s.r   = 1'b0;
            s1_nxt_s.s   = 1'b0;
        end else begin
            s1_nxt_s.mag = {8'h00, shr_mag_s};
            s1_nxt_s.g   = shr_g_s;
            s1_nxt_s.r   = shr_r_s;
            s1_nxt_s.s   = shr_s_s;
        end
    end

`ifndef OR_PFPU32_F2I_RNDMODES_EN
    logic unused_rmode_s;
    assign unused_rmode_s = ^s1_q.rmode;
`endif

    // Stage-2 round: increment decision, 33-bit add, saturation and negation
    always_comb begin
        inc_s = 1'b0;
`ifdef OR_PFPU32_F2I_RNDMODES_EN
        case (s1_q.rmode)
            RM_NEAREST: inc_s = s1_q.g & (s1_q.r | s1_q.s | s1_q.mag[0]);
            RM_TOZERO:  inc_s = 1'b0;
            RM_UP:      inc_s = ~s1_q.sign & (s1_q.g | s1_q.r | s1_q.s);
            RM_DOWN:    inc_s = s1_q.sign & (s1_q.g | s1_q.r | s1_q.s);
            default:    inc_s = 1'b0;
        endcase
`else
        inc_s = 1'b0;
`endif
        rmag_s = {1'b0, s1_q.mag} + {32'd0, inc_s};
        rovf_s = s1_q.ovf
               | (~s1_q.sign & (rmag_s > {1'b0, INT32_MAX_POS}))
               | ( s1_q.sign & (rmag_s > {1'b0, INT32_MAX_NEG}));
        if (rovf_s) begin
            int32_s   = s1_q.sign ? INT32_MAX_NEG : INT32_MAX_POS;
            invalid_s = 1'b1;
            inexact_s = 1'b0;
        end else begin
            int32_s   = s1_q.sign ? (~rmag_s[31:0] + 32'd1) : rmag_s[31:0];
            invalid_s = 1'b0;
            inexact_s = s1_q.g | s1_q.r | s1_q.s;
        end
    end

    // Pipe control: flush clears everything, adv advances, otherwise hold
    always_comb begin
        rdy1_d    = rdy1_q;
        s1_d      = s1_q;
        rdy2_d    = rdy2_q;
        int32_d   = int32_q;
        inexact_d = inexact_q;
        invalid_d = invalid_q;
        snan_d    = snan_q;
        if (flush_i) begin
            rdy1_d    = 1'b0;
            s1_d      = '0;
            rdy2_d    = 1'b0;
            int32_d   = 32'd0;
            inexact_d = 1'b0;
            invalid_d = 1'b0;
            snan_d    = 1'b0;
        end else if (adv_i) begin
            rdy1_d    = f2i_rdy_i;
            s1_d      = s1_nxt_s;
            rdy2_d    = rdy1_q;
            int32_d   = int32_s;
            inexact_d = inexact_s;
            invalid_d = invalid_s;
            snan_d    = s1_q.snan;
        end else begin
            rdy1_d    = rdy1_q;
            rdy2_d    = rdy2_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy1_q    <= 1'b0;
            s1_q      <= '0;
            rdy2_q    <= 1'b0;
            int32_q   <= 32'd0;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
            snan_q    <= 1'b0;
        end else begin
            rdy1_q    <= rdy1_d;
            s1_q      <= s1_d;
            rdy2_q    <= rdy2_d;
            int32_q   <= int32_d;
            inexact_q <= inexact_d;
            invalid_q <= invalid_d;
            snan_q    <= snan_d;
        end
    end

    assign f2i_rdy_o     = rdy2_q;
    assign f2i_int32_o   = int32_q;
    assign f2i_inexact_o = inexact_q;
    assign f2i_invalid_o = invalid_q;
    assign f2i_snan_o    = snan_q;

endmodule

// File: tb/tb_pu_or1k_pfpu32_f2i_rnd.sv
// Directed bench for pu_or1k_pfpu32_f2i_rnd; expectations follow OR_PFPU32_F2I_RNDMODES_EN.
module tb_pu_or1k_pfpu32_f2i_rnd;
    import pu_or1k_pfpu32_f2i_rnd_pkg::*;

`ifdef OR_PFPU32_F2I_RNDMODES_EN
    localparam bit RM_EN = 1'b1;
`else
    localparam bit RM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush_i, adv_i;
    logic [1:0]  rmode_i;
    logic        f2i_rdy_i, f2i_sign_i;
    logic [23:0] f2i_int24_i;
    logic [4:0]  f2i_shr_i;
    logic [3:0]  f2i_shl_i;
    logic        f2i_ovf_i, f2i_snan_i;
    logic        f2i_rdy_o;
    logic [31:0] f2i_int32_o;
    logic        f2i_inexact_o, f2i_invalid_o, f2i_snan_o;

    int total = 0;
    int bad   = 0;
    logic [35:0] obs_s;
    logic [35:0] exp_v;

    assign obs_s = {f2i_rdy_o, f2i_int32_o, f2i_inexact_o, f2i_invalid_o, f2i_snan_o};

    pu_or1k_pfpu32_f2i_rnd dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .adv_i         (adv_i),
        .rmode_i       (rmode_i),
        .f2i_rdy_i     (f2i_rdy_i),
        .f2i_sign_i    (f2i_sign_i),
        .f2i_int24_i   (f2i_int24_i),
        .f2i_shr_i     (f2i_shr_i),
        .f2i_shl_i     (f2i_shl_i),
        .f2i_ovf_i     (f2i_ovf_i),
        .f2i_snan_i    (f2i_snan_i),
        .f2i_rdy_o     (f2i_rdy_o),
        .f2i_int32_o   (f2i_int32_o),
        .f2i_inexact_o (f2i_inexact_o),
        .f2i_invalid_o (f2i_invalid_o),
        .f2i_snan_o    (f2i_snan_o)
    );

    always #5 clk = ~clk;

    // {rdy, int32, inexact, invalid, snan}
    function automatic logic [35:0] pk(input logic rdy, input logic [31:0] v,
                                       input logic inx, input logic inv, input logic sn);
        pk = {rdy, v, inx, inv, sn};
    endfunction

    task automatic set_in(input logic sg, input logic [23:0] i24, input logic [4:0] shr,
                          input logic [3:0] shl, input logic ovf, input logic sn,
                          input logic [1:0] rm);
        f2i_rdy_i   = 1'b1;
        f2i_sign_i  = sg;
        f2i_int24_i = i24;
        f2i_shr_i   = shr;
        f2i_shl_i   = shl;
        f2i_ovf_i   = ovf;
        f2i_snan_i  = sn;
        rmode_i     = rm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One vector through both stages; result is visible on return
    task automatic send(input logic sg, input logic [23:0] i24, input logic [4:0] shr,
                        input logic [3:0] shl, input logic ovf, input logic sn,
                        input logic [1:0] rm);
        set_in(sg, i24, shr, shl, ovf, sn, rm);
        tick();
        f2i_rdy_i = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        total++;
        if (obs_s !== 36'd0) begin
            bad++;
            $display("FAIL reset: got %h expected %h", obs_s, 36'd0);
        end
    endtask

    task automatic test_latency;
        set_in(1'b0, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_NEAREST);
        tick();
        f2i_rdy_i = 1'b0;
        total++;
        if (f2i_rdy_o !== 1'b0) begin
            bad++;
            $display("FAIL latency_1: rdy_o got %b expected 0", f2i_rdy_o);
        end
        tick();
        exp_v = pk(1'b1, RM_EN ? 32'd2 : 32'd1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++;
            $display("FAIL latency_2 (1.5 rne): got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_round_nearest;
        send(1'b0, 24'hA00000, 5'd22, 4'd0, 1'b0, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL rne_2p5: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'hE00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, RM_EN ? 32'd2 : 32'd1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL rne_1p75: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'hC00000, 5'd22, 4'd0, 1'b0, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL rne_exact3: got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_round_directed;
        send(1'b0, 24'hA00000, 5'd22, 4'd0, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, RM_EN ? 32'd3 : 32'd2, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL up_2p5: got %h expected %h", obs_s, exp_v);
        end
        send(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_TOZERO);
        exp_v = pk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL rtz_m1p5: got %h expected %h", obs_s, exp_v);
        end
        send(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_DOWN);
        exp_v = pk(1'b1, RM_EN ? 32'hFFFF_FFFE : 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL down_m1p5: got %h expected %h", obs_s, exp_v);
        end
        send(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL up_m1p5: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'h800001, 5'd23, 4'd0, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, RM_EN ? 32'd2 : 32'd1, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL up_sticky: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'h800000, 5'd31, 4'd0, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, RM_EN ? 32'd1 : 32'd0, 1'b1, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL up_shr31: got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_left_shift;
        send(1'b0, 24'hFFFFFF, 5'd0, 4'd7, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL shl7: got %h expected %h", obs_s, exp_v);
        end
        send(1'b1, 24'h800000, 5'd0, 4'd8, 1'b0, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL shl8_neg_min: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'h800000, 5'd0, 4'd8, 1'b0, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL shl8_pos_sat: got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_overflow;
        send(1'b1, 24'h123456, 5'd3, 4'd0, 1'b1, 1'b0, RM_NEAREST);
        exp_v = pk(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL ovf_neg: got %h expected %h", obs_s, exp_v);
        end
        send(1'b0, 24'hC00000, 5'd0, 4'd0, 1'b1, 1'b1, RM_DOWN);
        exp_v = pk(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL snan: got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_zero;
        send(1'b0, 24'h000000, 5'd5, 4'd0, 1'b0, 1'b0, RM_UP);
        exp_v = pk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL zero_pos: got %h expected %h", obs_s, exp_v);
        end
        send(1'b1, 24'h000000, 5'd0, 4'd0, 1'b0, 1'b0, RM_DOWN);
        exp_v = pk(1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL zero_neg: got %h expected %h", obs_s, exp_v);
        end
    endtask

    task automatic test_back_to_back_hold;
        logic [35:0] exp_a;
        logic [35:0] exp_b;
        exp_a = pk(1'b1, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0);
        exp_b = pk(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        set_in(1'b0, 24'hFFFFFF, 5'd0, 4'd7, 1'b0, 1'b0, RM_NEAREST);
        tick();
        set_in(1'b1, 24'h000001, 5'd0, 4'd0, 1'b1, 1'b0, RM_NEAREST);
        tick();
        total++;
        if (obs_s !== exp_a) begin
            bad++; $display("FAIL b2b_first: got %h expected %h", obs_s, exp_a);
        end
        adv_i     = 1'b0;
        f2i_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_s !== exp_a) begin
                bad++; $display("FAIL hold_%0d: got %h expected %h", i, obs_s, exp_a);
            end
        end
        adv_i = 1'b1;
        tick();
        total++;
        if (obs_s !== exp_b) begin
            bad++; $display("FAIL b2b_second: got %h expected %h", obs_s, exp_b);
        end
        tick();
        total++;
        if (f2i_rdy_o !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: rdy_o got %b expected 0", f2i_rdy_o);
        end
    endtask

    task automatic test_flush;
        set_in(1'b0, 24'hFFFFFF, 5'd0, 4'd7, 1'b1, 1'b1, RM_NEAREST);
        tick();
        flush_i   = 1'b1;
        f2i_rdy_i = 1'b0;
        tick();
        total++;
        if (obs_s !== 36'd0) begin
            bad++; $display("FAIL flush_clear: got %h expected %h", obs_s, 36'd0);
        end
        flush_i = 1'b0;
        tick();
        total++;
        if (obs_s !== 36'd0) begin
            bad++; $display("FAIL flush_no_result: got %h expected %h", obs_s, 36'd0);
        end
    endtask

    task automatic test_reset_mid;
        exp_v = pk(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        set_in(1'b0, 24'hC00000, 5'd0, 4'd0, 1'b1, 1'b1, RM_NEAREST);
        tick();
        set_in(1'b1, 24'hC00000, 5'd23, 4'd0, 1'b0, 1'b0, RM_TOZERO);
        tick();
        total++;
        if (obs_s !== exp_v) begin
            bad++; $display("FAIL rst_pre: got %h expected %h", obs_s, exp_v);
        end
        rst = 1'b1;
        tick();
        total++;
        if (obs_s !== 36'd0) begin
            bad++; $display("FAIL rst_mid: got %h expected %h", obs_s, 36'd0);
        end
        rst       = 1'b0;
        f2i_rdy_i = 1'b0;
        tick();
        total++;
        if (obs_s !== 36'd0) begin
            bad++; $display("FAIL rst_dropped: got %h expected %h", obs_s, 36'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        adv_i       = 1'b1;
        rmode_i     = 2'b00;
        f2i_rdy_i   = 1'b0;
        f2i_sign_i  = 1'b0;
        f2i_int24_i = 24'd0;
        f2i_shr_i   = 5'd0;
        f2i_shl_i   = 4'd0;
        f2i_ovf_i   = 1'b0;
        f2i_snan_i  = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_latency();
        test_round_nearest();
        test_round_directed();
        test_left_shift();
        test_overflow();
        test_zero();
        test_back_to_back_hold();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
